pipeline_buffer: RTL and testbench
==================================

PIPELINE_BUFFER -- requirements
Module: pipeline_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 54: payload bits per stage.
REQ-002 SHALL have parameter STAGES, default 2: number of register stages; legal range 1..8.
REQ-003 SHALL have parameter FLUSH_STAGES, default 1: stages 0..FLUSH_STAGES-1 are flushable; legal range 0..STAGES.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-007 SHALL have port in_data, input, DATA_WIDTH: payload entering stage 0.
REQ-008 SHALL have port in_ready, output, 1: stage 0 accepts this cycle.
REQ-009 SHALL have port out_valid, output, 1: valid bit of stage STAGES-1.
REQ-010 SHALL have port out_data, output, DATA_WIDTH: payload of stage STAGES-1.
REQ-011 SHALL have port out_ready, input, 1: consumer takes out_data this cycle.
REQ-012 SHALL have port flush, input, 1: kill the contents of the flushable stages.
REQ-013 SHALL have port count, output, $clog2(STAGES+1): number of valid stages.

Function
REQ-014 SHALL keep one valid bit and one DATA_WIDTH payload register per stage k (0 = input side, STAGES-1 = output side).
REQ-015 SHALL compute the advance signal combinationally: adv[STAGES-1] = out_ready | ~valid[STAGES-1], and adv[k] = adv[k+1] | ~valid[k] for k < STAGES-1.
REQ-016 SHALL drive in_ready = adv[0], giving bubble collapse: an empty stage accepts even while downstream is stalled.
REQ-017 SHALL, on an edge where adv[k] = 1, load stage k from stage k-1; stage 0 loads {in_valid, in_data}.
REQ-018 SHALL, on an edge where adv[k] = 0, hold both the valid bit and the payload of stage k.
REQ-019 SHALL count a transfer only when in_valid & in_ready, or out_valid & out_ready; latency with no stall is exactly STAGES cycles from input edge to out_valid.
REQ-020 SHALL sustain full throughput (one item per cycle) while out_ready = 1.
REQ-021 SHALL not change out_data or out_valid while out_valid = 1 and out_ready = 0.
REQ-022 SHALL, on an edge with flush = 1, clear valid[k] for all k < FLUSH_STAGES and drop the input that edge, even when in_valid & in_ready.
REQ-023 SHALL, on a flush edge with FLUSH_STAGES < STAGES and adv[FLUSH_STAGES] = 1, load stage FLUSH_STAGES with valid = 0; flushed items never escape the flushable region.
REQ-024 SHALL advance stages >= FLUSH_STAGES normally on a flush edge.
REQ-025 SHALL treat flush with FLUSH_STAGES = 0 as having no effect.
REQ-026 SHALL drive count as the population count of the valid bits; when count = STAGES and out_ready = 0, in_ready = 0 (full).
REQ-027 SHALL, when count = 0 (empty), drive out_valid = 0 and in_ready = 1.
REQ-028 SHALL be driven only from its registered valid bits and payloads: no combinational path from in_data to out_data.

Reset
REQ-029 SHALL, while rst = 1, asynchronously clear all valid bits and all payload registers to 0, so that out_valid = 0, out_data = 0, count = 0 and in_ready = 1.
REQ-030 SHALL discard all contents on rst asserted mid-operation, with no partial transfer, and resume on the first rising clk edge after rst deasserts.

Configuration
REQ-031 SHALL support the macro PIPELINE_BUFFER_FLUSH_ZERO_EN.
REQ-032 SHALL, with PIPELINE_BUFFER_FLUSH_ZERO_EN defined, zero the payload of every stage whose valid bit is cleared or loaded invalid by flush (REQ-022, REQ-023).
REQ-033 SHALL, without PIPELINE_BUFFER_FLUSH_ZERO_EN, clear only the valid bits on flush and leave the payloads unchanged (stale); all other behaviour is identical.

Verification (STAGES=3, DATA_WIDTH=16, FLUSH_STAGES=2)
REQ-034 SHALL cover streaming: inputs 0x0001..0x0005 on consecutive cycles with out_ready=1 -> out_valid first at cycle 3, outputs in order one per cycle, in_ready stays 1.
REQ-035 SHALL cover backpressure and bubble collapse: load 0xAAAA, hold out_ready=0, then send 0xBBBB and 0xCCCC -> both accepted, count=3, in_ready=0, out_data held at 0xAAAA; raise out_ready -> outputs AAAA, BBBB, CCCC.
REQ-036 SHALL cover flush: stages hold {0x0011, 0x0022, 0x0033} (stage 0..2), assert flush with in_valid=1 and in_data=0x0044, out_ready=1 -> 0x0033 output, count=0 after the edge, 0x0044 never appears; with ZERO_EN defined, stage payloads 0..2 read 0 after the edge.
REQ-037 SHALL cover flush under stall: full with out_ready=0, then flush -> count=1, out_data=0x0033 retained, in_ready=1.
REQ-038 SHALL cover reset mid-stream: rst asserted asynchronously with count=2 -> out_valid=0 and count=0 immediately without a clk edge; after deassert, 0x1234 appears at the output 3 cycles after it is accepted.

Source files
------------

// File: rtl/pipeline_buffer.sv
// Elastic register pipeline with bubble collapse and a flushable front region.
// Define PIPELINE_BUFFER_FLUSH_ZERO_EN to zero the payloads that flush invalidates.
module pipeline_buffer #(
    parameter int DATA_WIDTH   = 54,
    parameter int STAGES       = 2,
    parameter int FLUSH_STAGES = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    input  logic                           out_ready,
    input  logic                           flush,
    output logic [$clog2(STAGES+1)-1:0]    count
);
    localparam int CW = $clog2(STAGES+1);

    logic [STAGES-1:0]                 w_valid;
    logic [STAGES-1:0][DATA_WIDTH-1:0] w_data;
    logic [STAGES-1:0]                 w_adv;

    // Advance ripples from the output back toward the input; a running
    // variable avoids reading the vector being written.
    always_comb begin
        logic a;
        a = out_ready | ~w_valid[STAGES-1];
        w_adv = '0;
        w_adv[STAGES-1] = a;
        for (int k = STAGES-2; k >= 0; k--) begin
            a = a | ~w_valid[k];
            w_adv[k] = a;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam bit FLUSHABLE = (k < FLUSH_STAGES);
        // First non-flushable stage: whatever it takes in on a flush edge is dead.
        localparam bit BOUNDARY  = (k == FLUSH_STAGES) && (k > 0);

        logic                  r_v;
        logic [DATA_WIDTH-1:0] r_d;
        logic                  w_src_v;
        logic [DATA_WIDTH-1:0] w_src_d;

        if (k == 0) begin : g_head
            assign w_src_v = in_valid;
            assign w_src_d = in_data;
        end else begin : g_body
            assign w_src_v = w_valid[k-1];
            assign w_src_d = w_data[k-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_d <= '0;
            end else if (FLUSHABLE && flush) begin
                r_v <= 1'b0;
`ifdef PIPELINE_BUFFER_FLUSH_ZERO_EN
                r_d <= '0;
`endif
            end else if (w_adv[k]) begin
                if (BOUNDARY && flush) begin
                    r_v <= 1'b0;
`ifdef PIPELINE_BUFFER_FLUSH_ZERO_EN
                    r_d <= '0;
`else
                    r_d <= w_src_d;
`endif
                end else begin
                    r_v <= w_src_v;
                    r_d <= w_src_d;
                end
            end
        end

        assign w_valid[k] = r_v;
        assign w_data[k]  = r_d;
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < STAGES; k++)
            count = count + CW'(w_valid[k]);
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_valid[STAGES-1];
    assign out_data  = w_data[STAGES-1];
endmodule

// File: tb/tb_pipeline_buffer.sv
// Directed self-checking bench for pipeline_buffer (STAGES=3, DATA_WIDTH=16, FLUSH_STAGES=2).
module tb_pipeline_buffer;
    localparam int DW = 16;
    localparam int ST = 3;
    localparam int FS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          flush;
    logic [1:0]    count;

    int checks = 0;
    int errors = 0;

    pipeline_buffer #(.DATA_WIDTH(DW), .STAGES(ST), .FLUSH_STAGES(FS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_33_22_11();
        logic [DW-1:0] v [3];
        v[0] = 16'h0033; v[1] = 16'h0022; v[2] = 16'h0011;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = v[i];
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 2'd3) begin
            errors++; $display("FAIL fill_count: got %0d want 3", count);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || count !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: ov=%b od=%h cnt=%0d ir=%b want 0 0000 0 1",
                     out_valid, out_data, count, in_ready);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            if (n <= 5) begin
                in_valid = 1'b1; in_data = DW'(n);
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL stream_in_ready: n=%0d got %b want 1", n, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            checks++;
            if (out_valid !== (n >= 3)) begin
                errors++; $display("FAIL stream_valid: n=%0d got %b want %b", n, out_valid, n >= 3);
            end
            if (n >= 3) begin
                checks++;
                if (out_data !== DW'(n-2)) begin
                    errors++; $display("FAIL stream_data: n=%0d got %h want %h", n, out_data, DW'(n-2));
                end
            end
        end
        tick();
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain: cnt=%0d ov=%b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hAAAA;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hAAAA || count !== 2'd1) begin
            errors++; $display("FAIL bp_head: ov=%b od=%h cnt=%0d want 1 aaaa 1", out_valid, out_data, count);
        end
        in_valid = 1'b1; in_data = 16'hBBBB;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_data !== 16'hAAAA) begin
            errors++; $display("FAIL bp_collapse: ir=%b od=%h want 1 aaaa", in_ready, out_data);
        end
        in_data = 16'hCCCC;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 2'd3 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'hAAAA) begin
            errors++; $display("FAIL bp_full: cnt=%0d ir=%b ov=%b od=%h want 3 0 1 aaaa",
                               count, in_ready, out_valid, out_data);
        end
        tick();
        checks++;
        if (out_data !== 16'hAAAA || count !== 2'd3) begin
            errors++; $display("FAIL bp_hold: od=%h cnt=%0d want aaaa 3", out_data, count);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hBBBB) begin
            errors++; $display("FAIL bp_out_b: ov=%b od=%h want 1 bbbb", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hCCCC) begin
            errors++; $display("FAIL bp_out_c: ov=%b od=%h want 1 cccc", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++; $display("FAIL bp_empty: ov=%b cnt=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_flush();
        fill_33_22_11();
        out_ready = 1'b1; flush = 1'b1;
        in_valid = 1'b1; in_data = 16'h0044;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0033 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_pre: ov=%b od=%h ir=%b want 1 0033 1", out_valid, out_data, in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_post: cnt=%0d ov=%b want 0 0", count, out_valid);
        end
`ifdef PIPELINE_BUFFER_FLUSH_ZERO_EN
        checks++;
        if (out_data !== 16'h0) begin
            errors++; $display("FAIL flush_zero: od=%h want 0000", out_data);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || count !== 2'd0) begin
                errors++; $display("FAIL flush_escape: i=%0d ov=%b od=%h cnt=%0d want 0 - 0",
                                   i, out_valid, out_data, count);
            end
        end
    endtask

    task automatic test_flush_stall();
        fill_33_22_11();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (count !== 2'd1 || out_valid !== 1'b1 || out_data !== 16'h0033 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_stall: cnt=%0d ov=%b od=%h ir=%b want 1 1 0033 1",
                               count, out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_stall_drain: cnt=%0d ov=%b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0055;
        tick();
        in_data = 16'h0066;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 2'd2) begin
            errors++; $display("FAIL rstmid_pre: cnt=%0d want 2", count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_async: ov=%b cnt=%0d od=%h ir=%b want 0 0 0000 1",
                               out_valid, count, out_data, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready);
        end
        for (int n = 1; n <= 3; n++) begin
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== (n == 3)) begin
                errors++; $display("FAIL rstmid_latency: edge=%0d ov=%b want %b", n, out_valid, n == 3);
            end
        end
        checks++;
        if (out_data !== 16'h1234) begin
            errors++; $display("FAIL rstmid_data: od=%h want 1234", out_data);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_streaming();
        test_backpressure();
        test_flush();
        test_flush_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
